alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Multi-cycle controller that executes one register-to-register instruction at a time on the 8-bit logic ALU and the 8x8 single-read-port register file. It accepts instructions over a valid/ready handshake, fetches two operands serially through the one read port, and drives the ALU. It then writes the result back, and reports completion with a one-cycle done pulse. It sits between an instruction source (bench or future fetch unit) and the ALU/RegisterFile pair, owning every control input of both.

## Interface
- No parameters; data width 8, register index width 3, opcode width 2 are fixed constants.
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  sequencer can accept; high only in IDLE.
- instr_load  in  1  1 = load-immediate, 0 = ALU op.
- instr_op  in  2  00 AND, 01 OR, 10 NAND, 11 NOR; ignored when instr_load=1.
- instr_rd / instr_rs1 / instr_rs2  in  3 each  destination / operand registers; rs1/rs2 ignored on load.
- instr_imm  in  8  immediate for load.
- rf_read_reg  out  3  register-file read index.
- rf_read_data  in  8  register-file read data, combinational from rf_read_reg.
- rf_write_reg  out  3, rf_write_data  out  8, rf_write_enable  out  1  register-file write port.
- alu_opcode  out  2, alu_a  out  8, alu_b  out  8  ALU operands.
- alu_result  in  8  ALU output (combinational).
- done  out  1  one-cycle pulse, instruction retired.
- result  out  8  last written value, held until next retire.
- retired_count  out  8  instructions retired since reset, wraps.

## Operation
- States: IDLE, RD_A, RD_B, WB.
- IDLE: instr_ready=1. On instr_valid: latch op, rd, rs1, rs2, load flag, and imm. Load goes to WB with a_q=b_q=imm and op_q=OR. ALU op goes to RD_A. No valid: stay.
- RD_A: rf_read_reg=rs1_q; a_q<=rf_read_data at edge; go to RD_B.
- RD_B: rf_read_reg=rs2_q; b_q<=rf_read_data at edge; go to WB.
- WB:
  - Drives alu_opcode=op_q, alu_a=a_q, alu_b=b_q.
  - Drives rf_write_enable=1, rf_write_reg=rd_q, rf_write_data=alu_result.
  - At the edge: result<=alu_result, done<=1, retired_count+=1 (mod 256). Go to IDLE.
- Outside RD_A/RD_B, rf_read_reg=0. Outside WB, rf_write_enable=0 and alu_* drive the latched values (no glitch requirement).
- rd equal to rs1/rs2 of the next instruction: correct by construction, because the write lands at the WB edge before the next RD_A.
- rs1==rs2 is legal; the same register is read twice.
- Register contents are unreset; reading a never-written register yields X, which is propagated, not masked.

## Timing
- Reset: state=IDLE, instr_ready=1, done=0, result=0x00, retired_count=0x00, rf_write_enable=0, a_q=b_q=0, op_q=00.
- ALU op: accept edge at cycle 0, RD_A cycle 1, RD_B cycle 2, WB cycle 3. done is high in cycle 4; the register is readable from cycle 4.
- Load: accept at cycle 0, WB at cycle 1, done high in cycle 2.
- Throughput: one ALU op per 4 cycles, one load per 2 cycles. With instr_valid held high, the next accept happens in the IDLE cycle where done is high.
- instr_* sampled only on the accepting edge; later changes are ignored.
- rst asserted in any state: the next cycle is IDLE with reset values. An in-flight instruction is dropped, with no write and no done. A write in the WB cycle coinciding with rst still commits, because the register file has no reset.

## Structure
- Shared package `alu_seq_pkg`:
  - State enum (IDLE, RD_A, RD_B, WB).
  - Opcode constants OP_AND/OP_OR/OP_NAND/OP_NOR.
  - Widths DATA_W=8, REG_W=3, OP_W=2.
- Single flat module with no sub-module. A top-level `alu_seq_top` instantiating alu_op_sequencer, ALU and RegisterFile is the natural integration/test wrapper.

## Test plan
- Load r1=0xF0 then r2=0x3C: done at cycle 2 after each accept, result=0xF0 then 0x3C, retired_count=2.
- AND r3=r1,r2 -> rf_read_reg 1 then 2 in cycles 1-2, write r3=0x30 in cycle 3, done cycle 4, result=0x30.
- NAND r4, NOR r5, OR r6 from r1,r2 back-to-back with valid held -> results 0xCF, 0x03, 0xFC, accepts 4 cycles apart.
- Dependency: OR r1=r1,r1 after load r1=0x55, then AND r7=r1,r2 with r2=0x0F -> r7=0x05.
- Reset asserted in RD_B -> no rf_write_enable, no done, instr_ready=1 next cycle, retired_count unchanged from pre-op value 0 after reset.
- 256 loads -> retired_count wraps to 0x00; instr_valid low for 10 cycles -> stays IDLE, no done.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer: state encoding,
// logic-ALU opcodes and the fixed datapath widths.
package alu_seq_pkg;

    localparam int DATA_W = 8;
    localparam int REG_W  = 3;
    localparam int OP_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2,
        WB   = 2'd3
    } seq_state_t;

    localparam logic [OP_W-1:0] OP_AND  = 2'b00;
    localparam logic [OP_W-1:0] OP_OR   = 2'b01;
    localparam logic [OP_W-1:0] OP_NAND = 2'b10;
    localparam logic [OP_W-1:0] OP_NOR  = 2'b11;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Instruction channel between an instruction source (master) and the
// sequencer (slave), with a valid/ready handshake.
interface alu_op_sequencer_if;
    import alu_seq_pkg::*;

    logic              instr_valid;
    logic              instr_ready;
    logic              instr_load;
    logic [OP_W-1:0]   instr_op;
    logic [REG_W-1:0]  instr_rd;
    logic [REG_W-1:0]  instr_rs1;
    logic [REG_W-1:0]  instr_rs2;
    logic [DATA_W-1:0] instr_imm;

    modport master (
        output instr_valid,
        output instr_load,
        output instr_op,
        output instr_rd,
        output instr_rs1,
        output instr_rs2,
        output instr_imm,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_load,
        input  instr_op,
        input  instr_rd,
        input  instr_rs1,
        input  instr_rs2,
        input  instr_imm,
        output instr_ready
    );

endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller: accepts one instruction, reads two operands through
// the single register-file read port, drives the ALU and writes the result back.
module alu_op_sequencer
    import alu_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    alu_op_sequencer_if.slave  instr,
    output logic [REG_W-1:0]   rf_read_reg,
    input  logic [DATA_W-1:0]  rf_read_data,
    output logic [REG_W-1:0]   rf_write_reg,
    output logic [DATA_W-1:0]  rf_write_data,
    output logic               rf_write_enable,
    output logic [OP_W-1:0]    alu_opcode,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W-1:0]  alu_result,
    output logic               done,
    output logic [DATA_W-1:0]  result,
    output logic [7:0]         retired_count
);

    seq_state_t        state_reg;
    seq_state_t        state_next;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [OP_W-1:0]   op_reg;
    logic [REG_W-1:0]  rd_reg;
    logic [REG_W-1:0]  rs1_reg;
    logic [REG_W-1:0]  rs2_reg;
    logic              done_reg;
    logic [DATA_W-1:0] result_reg;
    logic [7:0]        retired_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        instr.instr_ready = 1'b0;
        rf_read_reg       = '0;
        rf_write_enable   = 1'b0;
        case (state_reg)
            IDLE: begin
                instr.instr_ready = 1'b1;
                if (instr.instr_valid) begin
                    state_next = instr.instr_load ? WB : RD_A;
                end
            end
            RD_A: begin
                rf_read_reg = rs1_reg;
                state_next  = RD_B;
            end
            RD_B: begin
                rf_read_reg = rs2_reg;
                state_next  = WB;
            end
            WB: begin
                rf_write_enable = 1'b1;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A load is folded into the ALU path as imm OR imm, so WB needs no special case.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg       <= '0;
            b_reg       <= '0;
            op_reg      <= OP_AND;
            rd_reg      <= '0;
            rs1_reg     <= '0;
            rs2_reg     <= '0;
            done_reg    <= 1'b0;
            result_reg  <= '0;
            retired_reg <= '0;
        end else begin
            done_reg <= (state_reg == WB);
            case (state_reg)
                IDLE: begin
                    if (instr.instr_valid) begin
                        rd_reg  <= instr.instr_rd;
                        rs1_reg <= instr.instr_rs1;
                        rs2_reg <= instr.instr_rs2;
                        if (instr.instr_load) begin
                            a_reg  <= instr.instr_imm;
                            b_reg  <= instr.instr_imm;
                            op_reg <= OP_OR;
                        end else begin
                            op_reg <= instr.instr_op;
                        end
                    end
                end
                RD_A: a_reg <= rf_read_data;
                RD_B: b_reg <= rf_read_data;
                WB: begin
                    result_reg  <= alu_result;
                    retired_reg <= retired_reg + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign rf_write_reg  = rd_reg;
    assign rf_write_data = alu_result;
    assign alu_opcode    = op_reg;
    assign alu_a         = a_reg;
    assign alu_b         = b_reg;
    assign done          = done_reg;
    assign result        = result_reg;
    assign retired_count = retired_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural logic ALU and an
// 8x8 register file wrapped around the sequencer.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_W-1:0]  rf_read_reg;
    logic [DATA_W-1:0] rf_read_data;
    logic [REG_W-1:0]  rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;
    logic              rf_write_enable;
    logic [OP_W-1:0]   alu_opcode;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              done;
    logic [DATA_W-1:0] result;
    logic [7:0]        retired_count;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_retired = 8'd0;

    alu_op_sequencer_if instr_bus ();

    alu_op_sequencer u_dut (
        .clk             (clk),
        .rst             (rst),
        .instr           (instr_bus.slave),
        .rf_read_reg     (rf_read_reg),
        .rf_read_data    (rf_read_data),
        .rf_write_reg    (rf_write_reg),
        .rf_write_data   (rf_write_data),
        .rf_write_enable (rf_write_enable),
        .alu_opcode      (alu_opcode),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_result      (alu_result),
        .done            (done),
        .result          (result),
        .retired_count   (retired_count)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] rf_mem [0:7];
    always @(posedge clk) begin
        if (rf_write_enable) rf_mem[rf_write_reg] <= rf_write_data;
    end
    assign rf_read_data = rf_mem[rf_read_reg];

    always_comb begin
        case (alu_opcode)
            2'b00:   alu_result = alu_a & alu_b;
            2'b01:   alu_result = alu_a | alu_b;
            2'b10:   alu_result = ~(alu_a & alu_b);
            default: alu_result = ~(alu_a | alu_b);
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_instr(input logic ld, input logic [1:0] op, input logic [2:0] rd,
                             input logic [2:0] rs1, input logic [2:0] rs2, input logic [7:0] imm);
        instr_bus.instr_load = ld;
        instr_bus.instr_op   = op;
        instr_bus.instr_rd   = rd;
        instr_bus.instr_rs1  = rs1;
        instr_bus.instr_rs2  = rs2;
        instr_bus.instr_imm  = imm;
    endtask

    // Load: accept, WB next cycle, done the cycle after.
    task automatic do_load(input logic [2:0] rd, input logic [7:0] imm, input bit verbose);
        set_instr(1'b1, 2'b00, rd, 3'd0, 3'd0, imm);
        instr_bus.instr_valid = 1'b1;
        chk("ld_ready", {7'd0, instr_bus.instr_ready}, 8'd1);
        tick();
        instr_bus.instr_valid = 1'b0;
        instr_bus.instr_imm   = ~imm;
        chk("ld_wb_we", {7'd0, rf_write_enable}, 8'd1);
        chk("ld_wb_reg", {5'd0, rf_write_reg}, {5'd0, rd});
        chk("ld_wb_data", rf_write_data, imm);
        tick();
        exp_retired = exp_retired + 8'd1;
        chk("ld_done", {7'd0, done}, 8'd1);
        chk("ld_result", result, imm);
        chk("ld_retired", retired_count, exp_retired);
        if (verbose) $display("load r%0d=%h result=%h retired=%0d", rd, imm, result, retired_count);
    endtask

    // ALU op with valid dropped after accept and fields scrambled to prove sampling.
    task automatic do_alu(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input logic [7:0] exp);
        set_instr(1'b0, op, rd, rs1, rs2, 8'h00);
        instr_bus.instr_valid = 1'b1;
        chk("alu_ready", {7'd0, instr_bus.instr_ready}, 8'd1);
        tick();
        instr_bus.instr_valid = 1'b0;
        set_instr(1'b1, ~op, ~rd, ~rs1, ~rs2, 8'hAA);
        chk("alu_rd_a", {5'd0, rf_read_reg}, {5'd0, rs1});
        chk("alu_rd_a_we", {7'd0, rf_write_enable}, 8'd0);
        tick();
        chk("alu_rd_b", {5'd0, rf_read_reg}, {5'd0, rs2});
        tick();
        chk("alu_wb_we", {7'd0, rf_write_enable}, 8'd1);
        chk("alu_wb_reg", {5'd0, rf_write_reg}, {5'd0, rd});
        chk("alu_wb_data", rf_write_data, exp);
        chk("alu_wb_op", {6'd0, alu_opcode}, {6'd0, op});
        tick();
        exp_retired = exp_retired + 8'd1;
        chk("alu_done", {7'd0, done}, 8'd1);
        chk("alu_result", result, exp);
        chk("alu_retired", retired_count, exp_retired);
        $display("alu op=%0d r%0d=r%0d,r%0d result=%h retired=%0d", op, rd, rs1, rs2, result, retired_count);
    endtask

    logic [1:0] b2b_op  [3];
    logic [2:0] b2b_rd  [3];
    logic [7:0] b2b_exp [3];

    initial begin
        rst = 1'b1;
        instr_bus.instr_valid = 1'b0;
        set_instr(1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 8'h00);
        tick();
        tick();
        chk("rst_ready", {7'd0, instr_bus.instr_ready}, 8'd1);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_result", result, 8'h00);
        chk("rst_retired", retired_count, 8'h00);
        chk("rst_we", {7'd0, rf_write_enable}, 8'd0);
        chk("rst_alu_a", alu_a, 8'h00);
        chk("rst_alu_b", alu_b, 8'h00);
        chk("rst_alu_op", {6'd0, alu_opcode}, 8'h00);
        chk("rst_rd_reg", {5'd0, rf_read_reg}, 8'h00);
        $display("reset: ready=%0d done=%0d retired=%0d", instr_bus.instr_ready, done, retired_count);
        rst = 1'b0;

        do_load(3'd1, 8'hF0, 1'b1);
        do_load(3'd2, 8'h3C, 1'b1);
        chk("two_loads_retired", retired_count, 8'd2);

        do_alu(OP_AND, 3'd3, 3'd1, 3'd2, 8'h30);

        // Back-to-back with valid held: each accept lands in the previous done cycle.
        b2b_op[0] = OP_NAND; b2b_rd[0] = 3'd4; b2b_exp[0] = 8'hCF;
        b2b_op[1] = OP_NOR;  b2b_rd[1] = 3'd5; b2b_exp[1] = 8'h03;
        b2b_op[2] = OP_OR;   b2b_rd[2] = 3'd6; b2b_exp[2] = 8'hFC;
        instr_bus.instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_instr(1'b0, b2b_op[i], b2b_rd[i], 3'd1, 3'd2, 8'h00);
            chk("b2b_ready", {7'd0, instr_bus.instr_ready}, 8'd1);
            tick();
            chk("b2b_rd_a", {5'd0, rf_read_reg}, 8'd1);
            tick();
            chk("b2b_rd_b", {5'd0, rf_read_reg}, 8'd2);
            tick();
            chk("b2b_wb_data", rf_write_data, b2b_exp[i]);
            if (i == 2) instr_bus.instr_valid = 1'b0;
            tick();
            exp_retired = exp_retired + 8'd1;
            chk("b2b_done", {7'd0, done}, 8'd1);
            chk("b2b_result", result, b2b_exp[i]);
            $display("b2b op=%0d r%0d result=%h retired=%0d", b2b_op[i], b2b_rd[i], result, retired_count);
        end
        chk("b2b_retired", retired_count, exp_retired);

        do_load(3'd1, 8'h55, 1'b1);
        do_alu(OP_OR, 3'd1, 3'd1, 3'd1, 8'h55);
        do_load(3'd2, 8'h0F, 1'b1);
        do_alu(OP_AND, 3'd7, 3'd1, 3'd2, 8'h05);
        chk("dep_retired", retired_count, 8'd10);

        // Reset while in RD_B drops the instruction.
        set_instr(1'b0, OP_AND, 3'd0, 3'd1, 3'd2, 8'h00);
        instr_bus.instr_valid = 1'b1;
        tick();
        instr_bus.instr_valid = 1'b0;
        tick();
        chk("rstb_in_rd_b", {5'd0, rf_read_reg}, 8'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_retired = 8'd0;
        chk("rstb_we", {7'd0, rf_write_enable}, 8'd0);
        chk("rstb_done", {7'd0, done}, 8'd0);
        chk("rstb_ready", {7'd0, instr_bus.instr_ready}, 8'd1);
        chk("rstb_retired", retired_count, 8'd0);
        tick();
        chk("rstb_done_after", {7'd0, done}, 8'd0);
        chk("rstb_we_after", {7'd0, rf_write_enable}, 8'd0);
        $display("reset in RD_B: ready=%0d done=%0d retired=%0d", instr_bus.instr_ready, done, retired_count);

        for (int i = 0; i < 256; i++) begin
            do_load(3'd3, 8'(i), (i == 0 || i >= 254));
        end
        chk("wrap_retired", retired_count, 8'h00);
        chk("wrap_result", result, 8'hFF);

        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_done", {7'd0, done}, 8'd0);
            chk("idle_ready", {7'd0, instr_bus.instr_ready}, 8'd1);
        end
        chk("idle_retired", retired_count, 8'h00);
        $display("idle 10 cycles: done=%0d ready=%0d", done, instr_bus.instr_ready);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
